nx_indirect_access_ram_port: RTL and testbench

//  Storage and arbitration stage directly downstream of the indirect-access controller.

---
 rtl/nx_indirect_access_ram_port.sv | 115 +++++++++++
 tb/tb_nx_indirect_access_ram_port.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/nx_indirect_access_ram_port.sv
// Flop-array storage behind the indirect-access controller: one sw port (read/write/compare)
// arbitrated against one hw read port, with a starvation counter that lifts sw priority.
module nx_indirect_access_ram_port #(
   parameter int                     N_DATA_BITS  = 64,
   parameter int                     N_ENTRIES    = 16,
   parameter int                     N_ADDR_BITS  = 5,
   parameter int                     N_INDEX_BITS = 4,
   parameter int                     STARVE_LIMIT = 7,
   parameter logic [N_DATA_BITS-1:0] RESET_DATA   = '0
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    sw_cs,
   input  logic                    sw_ce,
   input  logic                    sw_we,
   input  logic [N_ADDR_BITS-1:0]  sw_add,
   input  logic [N_DATA_BITS-1:0]  sw_wdat,
   output logic [N_DATA_BITS-1:0]  sw_rdat,
   output logic                    sw_match,
   output logic [N_INDEX_BITS-1:0] sw_aindex,
   output logic                    grant,
   input  logic                    yield,
   input  logic                    hw_rd_en,
   input  logic [N_ADDR_BITS-1:0]  hw_addr,
   output logic [N_DATA_BITS-1:0]  hw_rdat,
   output logic                    hw_rvalid,
   output logic                    hw_stall
);

   logic [N_DATA_BITS-1:0]  mem_q [N_ENTRIES];
   logic [3:0]              starve_q, starve_d;
   logic                    sw_pri, hw_acc, wr_en, rd_en, cmp_en;
   logic [N_DATA_BITS-1:0]  sw_sel, hw_sel;
   logic [N_ENTRIES-1:0]    hit_d, hit_q;
   logic                    cmp_vld_q;
   logic                    match_d;
   logic [N_INDEX_BITS-1:0] aindex_d;
   logic [N_DATA_BITS-1:0]  sw_rdat_q, hw_rdat_q;
   logic                    sw_match_q, hw_rvalid_q;
   logic [N_INDEX_BITS-1:0] sw_aindex_q;

   always_comb begin
      sw_pri   = yield | (starve_q >= 4'(STARVE_LIMIT));
      grant    = sw_cs & (~hw_rd_en | sw_pri);
      hw_stall = hw_rd_en & sw_cs & sw_pri;
      hw_acc   = hw_rd_en & ~hw_stall;
      wr_en    = grant & sw_we;
      rd_en    = grant & ~sw_we & ~sw_ce;
      cmp_en   = grant & sw_ce & ~sw_we;
      starve_d = starve_q;
      if (!sw_cs || grant)
         starve_d = '0;
      else if (starve_q != 4'hF)
         starve_d = starve_q + 4'd1;
   end

   // Address decode by equality so out-of-range addresses naturally select zero.
   always_comb begin
      sw_sel = '0;
      hw_sel = '0;
      hit_d  = '0;
      for (int i = 0; i < N_ENTRIES; i++) begin
         if (sw_add == N_ADDR_BITS'(i))  sw_sel = mem_q[i];
         if (hw_addr == N_ADDR_BITS'(i)) hw_sel = mem_q[i];
         hit_d[i] = (mem_q[i] == sw_wdat);
      end
   end

   always_comb begin
      match_d  = |hit_q;
      aindex_d = '0;
      for (int i = N_ENTRIES - 1; i >= 0; i--)
         if (hit_q[i]) aindex_d = N_INDEX_BITS'(i);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_ENTRIES; i++) mem_q[i] <= RESET_DATA;
      end else if (wr_en) begin
         for (int i = 0; i < N_ENTRIES; i++)
            if (sw_add == N_ADDR_BITS'(i)) mem_q[i] <= sw_wdat;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         starve_q    <= '0;
         sw_rdat_q   <= '0;
         hit_q       <= '0;
         cmp_vld_q   <= 1'b0;
         sw_match_q  <= 1'b0;
         sw_aindex_q <= '0;
         hw_rdat_q   <= '0;
         hw_rvalid_q <= 1'b0;
      end else begin
         starve_q    <= starve_d;
         cmp_vld_q   <= cmp_en;
         hw_rvalid_q <= hw_acc;
         if (rd_en)  sw_rdat_q <= sw_sel;
         if (cmp_en) hit_q     <= hit_d;
         if (cmp_vld_q) begin
            sw_match_q  <= match_d;
            sw_aindex_q <= aindex_d;
         end
         if (hw_acc) hw_rdat_q <= hw_sel;
      end
   end

   assign sw_rdat   = sw_rdat_q;
   assign sw_match  = sw_match_q;
   assign sw_aindex = sw_aindex_q;
   assign hw_rdat   = hw_rdat_q;
   assign hw_rvalid = hw_rvalid_q;

endmodule

// File: tb/tb_nx_indirect_access_ram_port.sv
// Scoreboard bench: driver predicts responses from an array model and queues them with a
// due cycle; a negedge monitor pops and compares against the DUT outputs.
module tb_nx_indirect_access_ram_port;

   localparam int NE = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        sw_cs = 0, sw_ce = 0, sw_we = 0, yield = 0, hw_rd_en = 0;
   logic [4:0]  sw_add = '0, hw_addr = '0;
   logic [63:0] sw_wdat = '0;
   logic [63:0] sw_rdat, hw_rdat;
   logic        sw_match, grant, hw_rvalid, hw_stall;
   logic [3:0]  sw_aindex;

   nx_indirect_access_ram_port dut (
      .clk(clk), .rst_n(rst_n), .sw_cs(sw_cs), .sw_ce(sw_ce), .sw_we(sw_we),
      .sw_add(sw_add), .sw_wdat(sw_wdat), .sw_rdat(sw_rdat), .sw_match(sw_match),
      .sw_aindex(sw_aindex), .grant(grant), .yield(yield), .hw_rd_en(hw_rd_en),
      .hw_addr(hw_addr), .hw_rdat(hw_rdat), .hw_rvalid(hw_rvalid), .hw_stall(hw_stall)
   );

   always #5 clk = ~clk;

   typedef struct { int due; logic [63:0] d; }          rd_t;
   typedef struct { int due; logic m; logic [3:0] idx; } cmp_t;

   rd_t  rq[$], hq[$];
   cmp_t cq[$];

   int          cyc = 0;
   int          total = 0, bad = 0;
   logic [63:0] mem [NE];
   int          wait_cnt = 0;
   logic [63:0] exp_rdat = '0;
   logic        exp_match = 1'b0;
   logic [3:0]  exp_aidx = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%h exp=%h cyc=%0d", name, act, exp, cyc);
      end
   endtask

   function automatic logic [63:0] mref(input logic [4:0] a);
      return (a < NE) ? mem[a] : 64'd0;
   endfunction

   // One clock edge of stimulus; predicts arbitration and queues responses.
   task automatic cycle(input logic cs, we, ce, input logic [4:0] add, input logic [63:0] wd,
                        input logic yl, hrd, input logic [4:0] ha, output logic g, output logic ga);
      logic pri, es;
      cmp_t c;
      @(posedge clk); #2;
      sw_cs = cs; sw_we = we; sw_ce = ce; sw_add = add; sw_wdat = wd;
      yield = yl; hw_rd_en = hrd; hw_addr = ha;
      #1;
      pri = yl || (wait_cnt >= 7);
      g   = cs && (!hrd || pri);
      es  = hrd && cs && pri;
      ga  = grant;
      chk("grant", grant, g);
      chk("hw_stall", hw_stall, es);
      if (hrd && !es) hq.push_back('{cyc + 1, mref(ha)});
      if (g) begin
         if (we) begin
            if (add < NE) mem[add] = wd;
         end else if (ce) begin
            c = '{cyc + 2, 1'b0, 4'd0};
            for (int i = NE - 1; i >= 0; i--)
               if (mem[i] == wd) begin c.m = 1'b1; c.idx = 4'(i); end
            cq.push_back(c);
         end else begin
            rq.push_back('{cyc + 1, mref(add)});
         end
      end
      wait_cnt = (cs && !g) ? ((wait_cnt < 15) ? wait_cnt + 1 : 15) : 0;
   endtask

   task automatic idle(input int n);
      logic g, ga;
      for (int i = 0; i < n; i++) cycle(0, 0, 0, 5'd0, 64'd0, 0, 0, 5'd0, g, ga);
   endtask

   task automatic sw_op(input logic we, ce, input logic [4:0] add, input logic [63:0] wd,
                        input logic yl, hrd, input logic [4:0] ha, output int n, output int first_ga);
      logic g, ga;
      n = 0; first_ga = 0;
      do begin
         cycle(1, we, ce, add, wd, yl, hrd, ha, g, ga);
         n++;
         if (ga && first_ga == 0) first_ga = n;
      end while (!g && n < 40);
   endtask

   task automatic do_reset();
      @(posedge clk); #2;
      rst_n = 1'b0;
      sw_cs = 0; sw_we = 0; sw_ce = 0; hw_rd_en = 0; yield = 0;
      rq.delete(); cq.delete(); hq.delete();
      exp_rdat = '0; exp_match = 1'b0; exp_aidx = '0;
      for (int i = 0; i < NE; i++) mem[i] = 64'd0;
      wait_cnt = 0;
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
   endtask

   always @(negedge clk) begin
      rd_t  r;
      cmp_t c;
      if (rq.size() > 0 && rq[0].due == cyc) begin r = rq.pop_front(); exp_rdat = r.d; end
      if (cq.size() > 0 && cq[0].due == cyc) begin
         c = cq.pop_front(); exp_match = c.m; exp_aidx = c.idx;
      end
      chk("sw_rdat", sw_rdat, exp_rdat);
      chk("sw_match", {63'd0, sw_match}, {63'd0, exp_match});
      chk("sw_aindex", {60'd0, sw_aindex}, {60'd0, exp_aidx});
      if (hq.size() > 0 && hq[0].due == cyc) begin
         r = hq.pop_front();
         chk("hw_rvalid", {63'd0, hw_rvalid}, 64'd1);
         chk("hw_rdat", hw_rdat, r.d);
      end else begin
         chk("hw_rvalid_idle", {63'd0, hw_rvalid}, 64'd0);
      end
   end

   initial begin
      int n, fg;
      logic g, ga;
      logic        pend, pwe, pce, yl, hrd;
      logic [4:0]  padd, ha;
      logic [63:0] pwd;
      logic [63:0] pool [4];
      pool[0] = 64'h55; pool[1] = 64'hAA; pool[2] = 64'h0; pool[3] = 64'h1234_5678_9ABC_DEF0;
      for (int i = 0; i < NE; i++) mem[i] = 64'd0;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
      idle(2);

      // Directed: write/read
      sw_op(1, 0, 5'd3, 64'hDEAD_BEEF, 0, 0, 5'd0, n, fg);
      sw_op(0, 0, 5'd3, 64'd0, 0, 0, 5'd0, n, fg);
      // Directed: compare
      sw_op(1, 0, 5'd5, 64'h55, 0, 0, 5'd0, n, fg);
      sw_op(1, 0, 5'd9, 64'h55, 0, 0, 5'd0, n, fg);
      sw_op(0, 1, 5'd0, 64'h55, 0, 0, 5'd0, n, fg);
      sw_op(0, 1, 5'd0, 64'h66, 0, 0, 5'd0, n, fg);
      idle(3);
      // Directed: starvation with hw held busy
      sw_op(0, 0, 5'd9, 64'd0, 0, 1, 5'd3, n, fg);
      chk("starve_grant_cycle", 64'(fg), 64'd8);
      // Directed: yield forces immediate sw priority
      sw_op(0, 0, 5'd5, 64'd0, 1, 1, 5'd9, n, fg);
      chk("yield_grant_cycle", 64'(fg), 64'd1);
      // Directed: out-of-range addresses
      sw_op(1, 0, 5'd20, 64'hFFFF, 0, 0, 5'd0, n, fg);
      sw_op(0, 0, 5'd20, 64'd0, 0, 0, 5'd0, n, fg);
      sw_op(0, 0, 5'd4, 64'd0, 0, 0, 5'd0, n, fg);
      cycle(0, 0, 0, 5'd0, 64'd0, 0, 1, 5'd20, g, ga);
      idle(3);
      // Directed: reset between compare grant and result
      sw_op(0, 1, 5'd0, 64'h55, 0, 0, 5'd0, n, fg);
      do_reset();
      idle(3);
      for (int i = 0; i < NE; i++) sw_op(0, 0, 5'(i), 64'd0, 0, 0, 5'd0, n, fg);
      sw_op(0, 1, 5'd0, 64'h0, 0, 0, 5'd0, n, fg);
      idle(3);

      // Random traffic
      pend = 0; pwe = 0; pce = 0; padd = '0; pwd = '0;
      for (int k = 0; k < 500; k++) begin
         if (!pend && ($urandom % 10) < 6) begin
            pend = 1;
            case ($urandom % 3)
               0: begin pwe = 1; pce = $urandom % 2; end
               1: begin pwe = 0; pce = 0; end
               default: begin pwe = 0; pce = 1; end
            endcase
            padd = 5'($urandom_range(0, 19));
            pwd  = pool[$urandom % 4];
         end
         hrd = ($urandom % 2) == 1;
         ha  = 5'($urandom_range(0, 19));
         yl  = ($urandom % 8) == 0;
         cycle(pend, pwe, pce, padd, pwd, yl, hrd, ha, g, ga);
         if (g) pend = 0;
      end
      idle(4);
      chk("rq_drained", 64'(rq.size()), 64'd0);
      chk("cq_drained", 64'(cq.size()), 64'd0);
      chk("hq_drained", 64'(hq.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

endmodule
